// File: rtl/mem_arbiter.sv
// Arbiter sequencing a single-ported unified memory between instruction fetch
// and the data-memory stage, including the end-of-program dump on halt.
module mem_arbiter #(
   parameter int LATENCY = 1,
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_data,
   output logic          if_done,
   output logic          if_stall,
   input  logic          dm_req,
   input  logic          dm_wr,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_done,
   output logic          dm_stall,
   input  logic          halt,
   output logic          mem_enable,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_createdump,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      HALTED
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [3:0]    count;
   logic          owner_data;
   logic          wr_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          grant_data;
   logic          grant_fetch;
   logic          start_dump;
   logic          finish;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A requester whose done is high still holds req for the access that just
   // finished, so it is not eligible for a new grant in that cycle.
   always_comb begin
      state_next  = state;
      grant_data  = 1'b0;
      grant_fetch = 1'b0;
      start_dump  = 1'b0;
      finish      = 1'b0;
      case (state)
         IDLE: begin
            if (dm_req && !dm_done) begin
               grant_data = 1'b1;
               state_next = BUSY;
            end else if (halt) begin
               start_dump = 1'b1;
               state_next = HALTED;
            end else if (if_req && !if_done) begin
               grant_fetch = 1'b1;
               state_next  = BUSY;
            end
         end
         BUSY: begin
            if (count == 4'd0) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The access is driven entirely from values latched at grant time, so the
   // requesters may change their inputs while the access is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         count          <= 4'd0;
         owner_data     <= 1'b0;
         wr_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         if_data        <= '0;
         dm_rdata       <= '0;
         if_done        <= 1'b0;
         dm_done        <= 1'b0;
         mem_createdump <= 1'b0;
      end else begin
         if_done        <= 1'b0;
         dm_done        <= 1'b0;
         mem_createdump <= start_dump;
         if (grant_data) begin
            owner_data <= 1'b1;
            addr_q     <= dm_addr;
            wr_q       <= dm_wr;
            wdata_q    <= dm_wdata;
            count      <= 4'(LATENCY - 1);
         end else if (grant_fetch) begin
            owner_data <= 1'b0;
            addr_q     <= if_addr;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            count      <= 4'(LATENCY - 1);
         end else if (state == BUSY && count != 4'd0) begin
            count <= count - 4'd1;
         end
         if (finish) begin
            if (owner_data) begin
               dm_done <= 1'b1;
               if (!wr_q) begin
                  dm_rdata <= mem_rdata;
               end
            end else begin
               if_done <= 1'b1;
               if_data <= mem_rdata;
            end
         end
      end
   end

   assign mem_enable = (state == BUSY);
   assign mem_wr     = (state == BUSY) && wr_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign busy       = (state != IDLE);
   assign if_stall   = if_req && !if_done;
   assign dm_stall   = dm_req && !dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LATENCY 1, 2, 4) each with a small
// behavioural memory; read results are queued at request time and popped at done.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        if_req         [3];
   logic [15:0] if_addr        [3];
   logic [15:0] if_data        [3];
   logic        if_done        [3];
   logic        if_stall       [3];
   logic        dm_req         [3];
   logic        dm_wr          [3];
   logic [15:0] dm_addr        [3];
   logic [15:0] dm_wdata       [3];
   logic [15:0] dm_rdata       [3];
   logic        dm_done        [3];
   logic        dm_stall       [3];
   logic        halt           [3];
   logic        mem_enable     [3];
   logic        mem_wr         [3];
   logic [15:0] mem_addr       [3];
   logic [15:0] mem_wdata      [3];
   logic [15:0] mem_rdata      [3];
   logic        mem_createdump [3];
   logic        busy           [3];

   logic [15:0] mem [3][1024];
   logic        pre_en;
   int          pre_inst;
   logic [9:0]  pre_addr;
   logic [15:0] pre_data;

   logic [15:0] sb[$];
   int compared   = 0;
   int mismatched = 0;

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         mem_arbiter #(
            .LATENCY((g == 0) ? 1 : (g == 1) ? 2 : 4),
            .AW(16),
            .DW(16)
         ) u_dut (
            .clk(clk),
            .rst(rst),
            .if_req(if_req[g]),
            .if_addr(if_addr[g]),
            .if_data(if_data[g]),
            .if_done(if_done[g]),
            .if_stall(if_stall[g]),
            .dm_req(dm_req[g]),
            .dm_wr(dm_wr[g]),
            .dm_addr(dm_addr[g]),
            .dm_wdata(dm_wdata[g]),
            .dm_rdata(dm_rdata[g]),
            .dm_done(dm_done[g]),
            .dm_stall(dm_stall[g]),
            .halt(halt[g]),
            .mem_enable(mem_enable[g]),
            .mem_wr(mem_wr[g]),
            .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .mem_createdump(mem_createdump[g]),
            .busy(busy[g])
         );
         assign mem_rdata[g] = (mem_enable[g] && !mem_wr[g]) ? mem[g][mem_addr[g][9:0]] : 16'h0000;
      end
   endgenerate

   // Single writer for the memory models: bench preloads and DUT stores.
   always @(posedge clk) begin
      if (pre_en) mem[pre_inst][pre_addr] <= pre_data;
      for (int i = 0; i < 3; i++) begin
         if (mem_enable[i] && mem_wr[i]) mem[i][mem_addr[i][9:0]] <= mem_wdata[i];
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkBit(string tag, logic obs, logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkWord(string tag, logic [15:0] obs, logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(int d, logic [9:0] a, logic [15:0] v);
      pre_en   = 1'b1;
      pre_inst = d;
      pre_addr = a;
      pre_data = v;
      stepCycle();
      pre_en   = 1'b0;
   endtask

   task automatic applyStimulus(int d, logic dmReq, logic dmWr, logic [15:0] dmAddr,
                                logic [15:0] dmWdata, logic ifReq, logic [15:0] ifAddr);
      dm_req[d]   = dmReq;
      dm_wr[d]    = dmWr;
      dm_addr[d]  = dmAddr;
      dm_wdata[d] = dmWdata;
      if_req[d]   = ifReq;
      if_addr[d]  = ifAddr;
   endtask

   // Called in the cycle a done pulse is due: checks the pulse, the other
   // requester's done, and the returned word against the scoreboard head.
   task automatic checkOutput(int d, logic isDm, string tag);
      logic [15:0] e;
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $error("[TB] FAIL %s: observed empty scoreboard expected pending entry", tag);
         return;
      end
      e = sb.pop_front();
      if (isDm) begin
         checkBit({tag, "_dm_done"}, dm_done[d], 1'b1);
         checkBit({tag, "_if_done"}, if_done[d], 1'b0);
         checkWord({tag, "_dm_rdata"}, dm_rdata[d], e);
      end else begin
         checkBit({tag, "_if_done"}, if_done[d], 1'b1);
         checkBit({tag, "_dm_done"}, dm_done[d], 1'b0);
         checkWord({tag, "_if_data"}, if_data[d], e);
      end
   endtask

   initial begin
      logic [15:0] vals [3];
      logic [15:0] lastIf;
      logic        sawDone;
      int          nextIdx;
      vals[0] = 16'h1111;
      vals[1] = 16'h2222;
      vals[2] = 16'h3333;
      pre_en   = 1'b0;
      pre_inst = 0;
      pre_addr = '0;
      pre_data = '0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(i, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
         halt[i] = 1'b0;
      end
      rst = 1'b1;
      stepCycle();
      stepCycle();

      for (int i = 0; i < 3; i++) begin
         checkBit("reset_busy", busy[i], 1'b0);
         checkBit("reset_mem_enable", mem_enable[i], 1'b0);
         checkWord("reset_mem_addr", mem_addr[i], 16'h0000);
         checkWord("reset_if_data", if_data[i], 16'h0000);
         checkBit("reset_createdump", mem_createdump[i], 1'b0);
      end
      rst = 1'b0;

      preload(0, 10'h010, 16'hA5A5);
      preload(0, 10'h100, 16'h1234);
      preload(0, 10'h002, 16'h5A5A);
      preload(1, 10'h020, vals[0]);
      preload(1, 10'h021, vals[1]);
      preload(1, 10'h022, vals[2]);

      // LATENCY=1 single fetch
      applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0010);
      sb.push_back(16'hA5A5);
      #1;
      checkBit("l1_t0_stall", if_stall[0], 1'b1);
      checkBit("l1_t0_enable", mem_enable[0], 1'b0);
      stepCycle();
      checkBit("l1_t1_enable", mem_enable[0], 1'b1);
      checkWord("l1_t1_addr", mem_addr[0], 16'h0010);
      checkBit("l1_t1_stall", if_stall[0], 1'b1);
      stepCycle();
      checkOutput(0, 1'b0, "l1_t2");
      checkBit("l1_t2_stall", if_stall[0], 1'b0);
      if_req[0] = 1'b0;
      stepCycle();
      checkBit("l1_t3_done", if_done[0], 1'b0);
      checkWord("l1_t3_hold", if_data[0], 16'hA5A5);

      // LATENCY=1 simultaneous requests: data first, fetch granted in dm done cycle
      applyStimulus(0, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b1, 16'h0002);
      sb.push_back(16'h1234);
      sb.push_back(16'h5A5A);
      stepCycle();
      checkWord("sim_t1_addr", mem_addr[0], 16'h0100);
      stepCycle();
      checkOutput(0, 1'b1, "sim_t2");
      dm_req[0] = 1'b0;
      stepCycle();
      checkWord("sim_t3_addr", mem_addr[0], 16'h0002);
      checkBit("sim_t3_enable", mem_enable[0], 1'b1);
      stepCycle();
      checkOutput(0, 1'b0, "sim_t4");
      if_req[0] = 1'b0;
      stepCycle();

      // LATENCY=2 continuous fetch: done every 4 cycles
      applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
      sb.push_back(vals[0]);
      lastIf  = 16'h0000;
      nextIdx = 1;
      for (int k = 0; k < 12; k++) begin
         if (k % 4 == 3) begin
            checkOutput(1, 1'b0, "cont_done");
            lastIf = vals[k / 4];
            if (nextIdx < 3) begin
               if_addr[1] = 16'h0020 + 16'(nextIdx);
               sb.push_back(vals[nextIdx]);
               nextIdx++;
            end else begin
               if_req[1] = 1'b0;
            end
         end else begin
            checkBit("cont_no_done", if_done[1], 1'b0);
            checkWord("cont_hold", if_data[1], lastIf);
         end
         stepCycle();
      end

      // LATENCY=4 store with requester inputs scrambled mid-access
      applyStimulus(2, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 1'b0, 16'h0);
      sb.push_back(16'h0000);
      for (int k = 1; k <= 4; k++) begin
         stepCycle();
         if (k == 1) begin
            dm_addr[2]  = 16'hDEAD;
            dm_wdata[2] = 16'h0BAD;
         end
         checkWord("st_addr", mem_addr[2], 16'h0200);
         checkBit("st_wr", mem_wr[2], 1'b1);
         checkWord("st_wdata", mem_wdata[2], 16'hBEEF);
         checkBit("st_no_done", dm_done[2], 1'b0);
      end
      stepCycle();
      checkOutput(2, 1'b1, "st_t5");
      dm_req[2] = 1'b0;
      checkWord("st_mem", mem[2][10'h200], 16'hBEEF);
      stepCycle();
      applyStimulus(2, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 16'h0);
      sb.push_back(16'hBEEF);
      repeat (5) stepCycle();
      checkOutput(2, 1'b1, "ld_t5");
      dm_req[2] = 1'b0;
      stepCycle();

      // LATENCY=4 reset in the second BUSY cycle
      applyStimulus(2, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 16'h0);
      stepCycle();
      stepCycle();
      rst = 1'b1;
      stepCycle();
      checkWord("rst_rdata", dm_rdata[2], 16'h0000);
      checkBit("rst_enable", mem_enable[2], 1'b0);
      checkWord("rst_addr", mem_addr[2], 16'h0000);
      checkBit("rst_busy", busy[2], 1'b0);
      checkBit("rst_done", dm_done[2], 1'b0);
      rst       = 1'b0;
      dm_req[2] = 1'b0;
      sawDone   = 1'b0;
      for (int k = 0; k < 8; k++) begin
         stepCycle();
         sawDone = sawDone | dm_done[2];
      end
      checkBit("rst_no_done_ever", sawDone, 1'b0);

      // Halt raised while a store is in flight
      applyStimulus(2, 1'b1, 1'b1, 16'h0300, 16'h7777, 1'b0, 16'h0);
      sb.push_back(16'h0000);
      stepCycle();
      halt[2] = 1'b1;
      checkBit("halt_busy", busy[2], 1'b1);
      repeat (4) stepCycle();
      checkOutput(2, 1'b1, "halt_store");
      checkBit("halt_no_dump_yet", mem_createdump[2], 1'b0);
      dm_req[2] = 1'b0;
      stepCycle();
      checkBit("halt_dump", mem_createdump[2], 1'b1);
      checkBit("halt_dump_enable", mem_enable[2], 1'b0);
      checkBit("halt_dump_busy", busy[2], 1'b1);
      if_req[2]  = 1'b1;
      if_addr[2] = 16'h0010;
      stepCycle();
      checkBit("halt_dump_once", mem_createdump[2], 1'b0);
      checkBit("halted_busy", busy[2], 1'b1);
      for (int k = 0; k < 10; k++) begin
         checkBit("halted_stall", if_stall[2], 1'b1);
         checkBit("halted_enable", mem_enable[2], 1'b0);
         checkBit("halted_dump", mem_createdump[2], 1'b0);
         stepCycle();
      end
      checkWord("halt_store_mem", mem[2][10'h300], 16'h7777);

      compared++;
      assert (sb.size() == 0) else begin
         mismatched++;
         $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
